regfile_wb_arbiter: RTL and testbench

- Shares the single register_file write channel (wr_ena/wr_addr/wr_data) between two writeback requesters: ALU and load unit (MEM).
- Keeps a per-register scoreboard of outstanding writes so the issue stage can detect RAW hazards on rs0/rs1.
- Sits between execute/memory stages and register_file. Drives register_file write ports directly from a registered output stage.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file writeback arbiter.
//   XLEN       - datapath width
//   REG_ADDR_W - register address width
//   NUM_REGS   - architectural register count (x00 hardwired, untracked)
//   wb_src_t   - writeback source, used for both the round-robin pointer and the grant
package regfile_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_src_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter with a registered priority pointer.
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   req[1:0]   - requests (bit 0 = ALU, bit 1 = MEM)
//   gnt[1:0]   - one-hot grant; exactly one bit is high every cycle, even with no request,
//                so the grant never depends on the losing requester's payload
module rr_arbiter2
   import regfile_pkg::*;
#(
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   wb_src_t prio_q, prio_d, sel;

   always_comb begin
      case (req)
         2'b01:   sel = WB_ALU;
         2'b10:   sel = WB_MEM;
         default: sel = prio_q;
      endcase
      // Any activity hands priority to whichever source was not served.
      prio_d = prio_q;
      if (req != 2'b00) prio_d = (sel == WB_ALU) ? WB_MEM : WB_ALU;
      gnt = (sel == WB_ALU) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prio_q <= wb_src_t'(RESET_PRIO);
      else      prio_q <= prio_d;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register_file write port between the ALU and load unit
// and keeps a per-register outstanding-write scoreboard for RAW hazard detection.
//   clk, rst                         - clock (rising edge), async active-low reset
//   alu_valid/ready/rd/data          - ALU writeback handshake
//   mem_valid/ready/rd/data          - load writeback handshake
//   issue_valid/rd, issue_ready      - issued destination; ready low when its counter is full
//   rs0, rs1, busy0, busy1           - source registers and their outstanding-write status
//   wr_ena, wr_addr, wr_data         - registered write port to register_file
//   sb_err                           - sticky: commit to a register whose count was zero
// Optional macro REGFILE_WB_FORWARD_EN adds fwd0/fwd1 and fwd_data0/fwd_data1, flagging
// that the value in the write stage is the last outstanding write for rs0/rs1.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned CNT_W      = 2,
   parameter bit          RESET_PRIO = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [XLEN-1:0]       mem_data,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   output logic                  issue_ready,
   input  logic [REG_ADDR_W-1:0] rs0,
   input  logic [REG_ADDR_W-1:0] rs1,
   output logic                  busy0,
   output logic                  busy1,
   output logic                  wr_ena,
   output logic [REG_ADDR_W-1:0] wr_addr,
   output logic [XLEN-1:0]       wr_data,
   output logic                  sb_err
`ifdef REGFILE_WB_FORWARD_EN
   ,
   output logic                  fwd0,
   output logic                  fwd1,
   output logic [XLEN-1:0]       fwd_data0,
   output logic [XLEN-1:0]       fwd_data1
`endif
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [1:0]            gnt;
   logic                  fire;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;
   logic                  issue_fire, commit;

   logic                  wr_ena_q;
   logic [REG_ADDR_W-1:0] wr_addr_q;
   logic [XLEN-1:0]       wr_data_q;
   logic                  sb_err_q, sb_err_d;
   logic [CNT_W-1:0]      cnt_q [NUM_REGS];
   logic [CNT_W-1:0]      cnt_d [NUM_REGS];

   rr_arbiter2 #(
      .RESET_PRIO (RESET_PRIO)
   ) u_arb (
      .clk (clk),
      .rst (rst),
      .req ({mem_valid, alu_valid}),
      .gnt (gnt)
   );

   assign alu_ready = gnt[0];
   assign mem_ready = gnt[1];
   assign fire      = (alu_valid && gnt[0]) || (mem_valid && gnt[1]);
   assign sel_rd    = gnt[1] ? mem_rd   : alu_rd;
   assign sel_data  = gnt[1] ? mem_data : alu_data;

   // x00 is never incremented, so its counter stays zero and reads as not busy / not full.
   assign issue_ready = (cnt_q[issue_rd] != CntMax);
   assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
   // Counters retire on the register_file commit edge, not on the handshake edge.
   assign commit      = wr_ena_q && (wr_addr_q != '0);

   always_comb begin
      cnt_d    = cnt_q;
      sb_err_d = sb_err_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         logic inc, dec;
         inc = issue_fire && (issue_rd == REG_ADDR_W'(i));
         dec = commit && (wr_addr_q == REG_ADDR_W'(i));
         if (inc && !dec) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (dec && !inc) begin
            if (cnt_q[i] == '0) sb_err_d = 1'b1;
            else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ena_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         sb_err_q  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      end else begin
         // rd=0 still completes the handshake but never reaches the register file.
         wr_ena_q <= fire && (sel_rd != '0);
         if (fire) begin
            wr_addr_q <= sel_rd;
            wr_data_q <= sel_data;
         end
         sb_err_q <= sb_err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign wr_ena  = wr_ena_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign sb_err  = sb_err_q;
   assign busy0   = (cnt_q[rs0] != '0);
   assign busy1   = (cnt_q[rs1] != '0);

`ifdef REGFILE_WB_FORWARD_EN
   // Forward only when the write in flight is the last one outstanding for that source.
   assign fwd0      = wr_ena_q && (wr_addr_q == rs0) && (rs0 != '0) && (cnt_q[rs0] == CNT_W'(1));
   assign fwd1      = wr_ena_q && (wr_addr_q == rs1) && (rs1 != '0) && (cnt_q[rs1] == CNT_W'(1));
   assign fwd_data0 = wr_data_q;
   assign fwd_data1 = wr_data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter. Each driven cycle pushes
// the expected write-stage contents; they are popped and compared one cycle later.
// Honours REGFILE_WB_FORWARD_EN for the forwarding outputs.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   localparam int CNT_W = 2;
   localparam int MAXC  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_valid, alu_ready, mem_valid, mem_ready;
   logic [4:0]  alu_rd, mem_rd, issue_rd, rs0, rs1, wr_addr;
   logic [31:0] alu_data, mem_data, wr_data;
   logic        issue_valid, issue_ready, busy0, busy1, wr_ena, sb_err;
`ifdef REGFILE_WB_FORWARD_EN
   logic        fwd0, fwd1;
   logic [31:0] fwd_data0, fwd_data1;
`endif

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .CNT_W      (CNT_W),
      .RESET_PRIO (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .rs0         (rs0),
      .rs1         (rs1),
      .busy0       (busy0),
      .busy1       (busy1),
      .wr_ena      (wr_ena),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .sb_err      (sb_err)
`ifdef REGFILE_WB_FORWARD_EN
      ,
      .fwd0        (fwd0),
      .fwd1        (fwd1),
      .fwd_data0   (fwd_data0),
      .fwd_data1   (fwd_data1)
`endif
   );

   typedef struct packed {
      logic        ena;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  cur;
   int   checks = 0;
   int   errors = 0;
   int   mcnt[32];
   logic mprio;
   logic merr;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Async reset: outputs must clear before any clock edge.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      check_val("rst_wr_ena", wr_ena, 1'b0);
      check_val("rst_wr_addr", wr_addr, 5'd0);
      check_val("rst_wr_data", wr_data, 32'd0);
      check_val("rst_busy0", busy0, 1'b0);
      check_val("rst_busy1", busy1, 1'b0);
      check_val("rst_sb_err", sb_err, 1'b0);
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      mprio = 1'b0;
      merr  = 1'b0;
      cur   = '0;
      exp_q.delete();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // One cycle, entered and left at a falling edge.
   task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic iv, input logic [4:0] ird);
      logic eg, fire, eir, inc, dec, efwd;
      logic [4:0] rd;
      wr_t nw;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      issue_valid = iv; issue_rd = ird;
      #1;
      if (av && !mv)      eg = 1'b0;
      else if (mv && !av) eg = 1'b1;
      else                eg = mprio;
      check_val("alu_ready", alu_ready, !eg);
      check_val("mem_ready", mem_ready, eg);
      eir = (mcnt[ird] != MAXC);
      check_val("issue_ready", issue_ready, eir);
      check_val("busy0", busy0, mcnt[rs0] != 0);
      check_val("busy1", busy1, mcnt[rs1] != 0);
      check_val("sb_err", sb_err, merr);
      efwd = cur.ena && cur.addr == rs0 && rs0 != 0 && mcnt[rs0] == 1;
`ifdef REGFILE_WB_FORWARD_EN
      check_val("fwd0", fwd0, efwd);
      if (efwd) check_val("fwd_data0", fwd_data0, cur.data);
`endif
      fire    = eg ? mv : av;
      rd      = eg ? mrd : ard;
      nw.ena  = fire && rd != 0;
      nw.addr = rd;
      nw.data = eg ? md : ad;
      exp_q.push_back(nw);
      if (av || mv) mprio = !eg;
      for (int r = 1; r < 32; r++) begin
         inc = iv && eir && ird == r;
         dec = cur.ena && cur.addr == r;
         if (inc && !dec) mcnt[r]++;
         else if (dec && !inc) begin
            if (mcnt[r] == 0) merr = 1'b1;
            else              mcnt[r]--;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         check_val("scoreboard_empty", 1'b1, 1'b0);
      end else begin
         cur = exp_q.pop_front();
         check_val("wr_ena", wr_ena, cur.ena);
         if (cur.ena) begin
            check_val("wr_addr", wr_addr, cur.addr);
            check_val("wr_data", wr_data, cur.data);
         end
      end
   endtask

   task automatic idle();
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   initial begin
      rs0 = '0;
      rs1 = '0;
      do_reset();

      // Single ALU writeback with a matching issue.
      rs0 = 5'd5;
      cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
      idle();
      idle();

      // Both requesters held: strict alternation ALU, MEM, ALU, MEM.
      do_reset();
      rs0 = 5'd3; rs1 = 5'd4;
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 5'd3, 32'hA0 + i, 1'b1, 5'd4, 32'hB0 + i, 1'b0, 5'd0);
      idle();
      // Lone MEM request after the ALU ran dry.
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h55, 1'b0, 5'd0);
      idle();

      // Counter saturation on x07 and busy through the last commit.
      do_reset();
      rs0 = 5'd7; rs1 = 5'd0;
      for (int i = 0; i < 4; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      for (int i = 0; i < 3; i++) cyc(1'b1, 5'd7, 32'h70 + i, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      idle();
      idle();

      // Same-edge issue and commit, rd=0 writeback, sticky error on zero-count commit.
      do_reset();
      rs0 = 5'd9; rs1 = 5'd12;
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
      cyc(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
      idle();
      cyc(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      idle();
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC12, 1'b0, 5'd0);
      idle();
      idle();
      idle();

      // Reset while a write sits in the output stage.
      do_reset();
      rs0 = 5'd10; rs1 = 5'd11;
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAAAA, 1'b0, 5'd0);
      do_reset();
      idle();

      // Forwarding: one pending write forwards, two pending writes do not.
      rs0 = 5'd6; rs1 = 5'd0;
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
      cyc(1'b1, 5'd6, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      idle();
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
      cyc(1'b1, 5'd6, 32'h5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
